// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Lane geometry and the read-encoding of WEB live here so both levels agree.
package dm_pkg;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dm_state_t;

    localparam int          LANE_W   = 8;
    localparam int          LANES    = 4;
    localparam int          DATA_W   = LANE_W * LANES;
    localparam logic [3:0]  WEB_READ = 4'b1111;

    // Active-low byte enables from the core become active-high lane writes.
    function automatic logic [LANES-1:0] web_to_we(input logic [LANES-1:0] web);
        return ~web;
    endfunction

endpackage

// File: rtl/dm_sram_if.sv
// Data-memory port between the MEM stage (master) and dm_sram (slave).
// ADDR_W must match the ADDR_W of the dm_sram it is connected to.
interface dm_sram_if #(
    parameter int ADDR_W = 14
) ();
    logic              CS;
    logic [3:0]        WEB;
    logic [ADDR_W-1:0] A;
    logic [31:0]       DI;
    logic [31:0]       DO;
    logic              busy;
    logic              addr_err;

    modport master (
        output CS, WEB, A, DI,
        input  DO, busy, addr_err
    );

    modport slave (
        input  CS, WEB, A, DI,
        output DO, busy, addr_err
    );
endinterface

// File: rtl/dm_array.sv
// Byte-writable word storage: one narrow RAM per lane, each with a registered
// read port that supports a synchronous clear and a read enable (hold).
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic              rclr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [DEPTH];
            logic [LANE_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
            end

            // Output register clears take priority so reset and out-of-range
            // reads both force the lane to zero.
            always_ff @(posedge clk) begin
                if (rclr) begin
                    rdata_reg <= '0;
                end else if (re) begin
                    rdata_reg <= mem[addr];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/dm_sram.sv
// Data-memory responder: post-reset clear sequence, range checking and
// control of the registered read data and addr_err pulse.
module dm_sram
    import dm_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic      clk,
    input  logic      rst,
    dm_sram_if.slave  bus
);

    // Counter is one bit wider than the address so DEPTH = 2^ADDR_W fits.
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned LAST_U  = DEPTH - 1;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH_U[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_C  = LAST_U[ADDR_W:0];

    dm_state_t         state_reg, state_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              addr_err_reg, addr_err_next;

    logic              in_range;
    logic              is_read;
    logic              access;

    logic [LANES-1:0]  arr_we;
    logic              arr_re;
    logic              arr_rclr;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign in_range = ({1'b0, bus.A} < DEPTH_C);
    assign is_read  = (bus.WEB == WEB_READ);
    assign access   = (state_reg == DM_READY) && bus.CS;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_err_next = 1'b0;
        case (state_reg)
            DM_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_C) begin
                    state_next = DM_READY;
                end
            end
            DM_READY: begin
                addr_err_next = access && !in_range;
            end
            default: begin
                state_next = DM_CLEAR;
            end
        endcase
    end

    always_comb begin
        arr_we    = '0;
        arr_re    = 1'b0;
        arr_rclr  = rst;
        arr_addr  = bus.A;
        arr_wdata = bus.DI;
        if (!rst) begin
            if (state_reg == DM_CLEAR) begin
                arr_we    = '1;
                arr_addr  = cnt_reg[ADDR_W-1:0];
                arr_wdata = '0;
            end else if (access) begin
                if (in_range) begin
                    if (is_read) begin
                        arr_re = 1'b1;
                    end else begin
                        arr_we = web_to_we(bus.WEB);
                    end
                end else if (is_read) begin
                    // Out-of-range read returns zero; out-of-range write is dropped.
                    arr_rclr = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DM_CLEAR;
            cnt_reg      <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_err_reg <= addr_err_next;
        end
    end

    dm_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .rclr  (arr_rclr),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign bus.DO       = arr_rdata;
    assign bus.busy     = (state_reg == DM_CLEAR);
    assign bus.addr_err = addr_err_reg;

endmodule

// File: tb/tb_dm_sram.sv
// Directed bench for dm_sram: a DEPTH=16 instance for clear/data/lane tests and
// a DEPTH=10 instance for out-of-range behaviour.
module tb_dm_sram;

    logic clk;
    logic rst16;
    logic rst10;
    int   checks;
    int   errors;

    dm_sram_if #(.ADDR_W(4)) bus16 ();
    dm_sram_if #(.ADDR_W(4)) bus10 ();

    dm_sram #(.DEPTH(16), .ADDR_W(4)) u_dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16)
    );

    dm_sram #(.DEPTH(10), .ADDR_W(4)) u_dut10 (
        .clk (clk),
        .rst (rst10),
        .bus (bus10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access, let the edge sample it, return 1 time unit later.
    task automatic acc16(input logic cs, input logic [3:0] web, input logic [3:0] a,
                         input logic [31:0] di);
        bus16.CS  = cs;
        bus16.WEB = web;
        bus16.A   = a;
        bus16.DI  = di;
        @(posedge clk);
        #1;
    endtask

    task automatic acc10(input logic cs, input logic [3:0] web, input logic [3:0] a,
                         input logic [31:0] di);
        bus10.CS  = cs;
        bus10.WEB = web;
        bus10.A   = a;
        bus10.DI  = di;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse on DUT16 then count busy cycles, checking DO/addr_err stay 0.
    task automatic reset_and_count16(input string tag);
        int  busy_cnt;
        bit  quiet_ok;
        rst16 = 1'b1;
        acc16(1'b1, 4'b0000, 4'd5, 32'hFFFF_FFFF);
        rst16 = 1'b0;
        checks++;
        if (bus16.busy !== 1'b1 || bus16.DO !== 32'h0 || bus16.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_reset: busy=%b DO=%h addr_err=%b required busy=1 DO=00000000 addr_err=0",
                     tag, bus16.busy, bus16.DO, bus16.addr_err);
        end
        busy_cnt = 1;
        quiet_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus16.DO !== 32'h0 || bus16.addr_err !== 1'b0) quiet_ok = 1'b0;
            if (bus16.busy === 1'b1) busy_cnt++;
            else break;
        end
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles required 16", tag, busy_cnt);
        end
        checks++;
        if (!quiet_ok) begin
            errors++;
            $display("FAIL %s_quiet_during_clear: DO/addr_err nonzero during clear, required 0", tag);
        end
        bus16.CS = 1'b0;
    endtask

    task automatic read_all_zero16(input string tag);
        for (int a = 0; a < 16; a++) begin
            acc16(1'b1, 4'b1111, 4'(a), 32'h0);
            checks++;
            if (bus16.DO !== 32'h0) begin
                errors++;
                $display("FAIL %s_zero_read A=%0d: got %h required 00000000", tag, a, bus16.DO);
            end
        end
        bus16.CS = 1'b0;
    endtask

    task automatic test_reset();
        reset_and_count16("reset");
        read_all_zero16("reset");
    endtask

    task automatic test_write_read();
        acc16(1'b1, 4'b0000, 4'd3, 32'hDEAD_BEEF);
        checks++;
        if (bus16.DO !== 32'h0 || bus16.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL write_holds_do: DO=%h addr_err=%b required DO=00000000 addr_err=0",
                     bus16.DO, bus16.addr_err);
        end
        acc16(1'b1, 4'b1111, 4'd3, 32'h0);
        checks++;
        if (bus16.DO !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read: got %h required deadbeef", bus16.DO);
        end
    endtask

    task automatic test_lanes();
        acc16(1'b1, 4'b1101, 4'd3, 32'h0000_AB00);
        acc16(1'b1, 4'b1111, 4'd3, 32'h0);
        checks++;
        if (bus16.DO !== 32'hDEAD_ABEF) begin
            errors++;
            $display("FAIL lane_byte1: got %h required deadabef", bus16.DO);
        end
        acc16(1'b1, 4'b0011, 4'd3, 32'h1234_0000);
        acc16(1'b1, 4'b1111, 4'd3, 32'h0);
        checks++;
        if (bus16.DO !== 32'h1234_ABEF) begin
            errors++;
            $display("FAIL lane_half_hi: got %h required 1234abef", bus16.DO);
        end
    endtask

    task automatic test_cs_low();
        acc16(1'b0, 4'b0000, 4'd3, 32'h0);
        checks++;
        if (bus16.DO !== 32'h1234_ABEF || bus16.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL cs_low_hold: DO=%h addr_err=%b required DO=1234abef addr_err=0",
                     bus16.DO, bus16.addr_err);
        end
        acc16(1'b1, 4'b1111, 4'd4, 32'h0);
        acc16(1'b1, 4'b1111, 4'd3, 32'h0);
        checks++;
        if (bus16.DO !== 32'h1234_ABEF) begin
            errors++;
            $display("FAIL cs_low_array: got %h required 1234abef", bus16.DO);
        end
    endtask

    task automatic test_back_to_back();
        acc16(1'b1, 4'b0000, 4'd5, 32'hAAAA_5555);
        acc16(1'b1, 4'b0000, 4'd6, 32'h1122_3344);
        acc16(1'b1, 4'b1111, 4'd5, 32'h0);
        checks++;
        if (bus16.DO !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL b2b_read5: got %h required aaaa5555", bus16.DO);
        end
        acc16(1'b1, 4'b1111, 4'd6, 32'h0);
        checks++;
        if (bus16.DO !== 32'h1122_3344) begin
            errors++;
            $display("FAIL b2b_read6: got %h required 11223344", bus16.DO);
        end
        acc16(1'b1, 4'b1111, 4'd15, 32'h0);
        checks++;
        if (bus16.DO !== 32'h0 || bus16.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_word: DO=%h addr_err=%b required DO=00000000 addr_err=0",
                     bus16.DO, bus16.addr_err);
        end
        bus16.CS = 1'b0;
    endtask

    task automatic test_range();
        int wait_cnt;
        wait_cnt = 0;
        while (bus10.busy !== 1'b0 && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        checks++;
        if (bus10.busy !== 1'b0) begin
            errors++;
            $display("FAIL range_clear_timeout: busy=%b required 0", bus10.busy);
        end
        acc10(1'b1, 4'b0000, 4'd2, 32'hCAFE_F00D);
        acc10(1'b1, 4'b1111, 4'd2, 32'h0);
        checks++;
        if (bus10.DO !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL range_read2: got %h required cafef00d", bus10.DO);
        end
        acc10(1'b1, 4'b1111, 4'd12, 32'h0);
        checks++;
        if (bus10.DO !== 32'h0 || bus10.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL range_read12: DO=%h addr_err=%b required DO=00000000 addr_err=1",
                     bus10.DO, bus10.addr_err);
        end
        acc10(1'b0, 4'b1111, 4'd12, 32'h0);
        checks++;
        if (bus10.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL range_pulse_len: addr_err=%b required 0", bus10.addr_err);
        end
        acc10(1'b1, 4'b1111, 4'd2, 32'h0);
        acc10(1'b1, 4'b0000, 4'd12, 32'hFFFF_FFFF);
        checks++;
        if (bus10.DO !== 32'hCAFE_F00D || bus10.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL range_write12: DO=%h addr_err=%b required DO=cafef00d addr_err=1",
                     bus10.DO, bus10.addr_err);
        end
        acc10(1'b1, 4'b1111, 4'd2, 32'h0);
        checks++;
        if (bus10.DO !== 32'hCAFE_F00D || bus10.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL range_alias2: DO=%h addr_err=%b required DO=cafef00d addr_err=0",
                     bus10.DO, bus10.addr_err);
        end
        acc10(1'b1, 4'b1111, 4'd9, 32'h0);
        checks++;
        if (bus10.DO !== 32'h0 || bus10.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL range_last_valid: DO=%h addr_err=%b required DO=00000000 addr_err=0",
                     bus10.DO, bus10.addr_err);
        end
        acc10(1'b1, 4'b1111, 4'd2, 32'h0);
        acc10(1'b1, 4'b1111, 4'd10, 32'h0);
        checks++;
        if (bus10.DO !== 32'h0 || bus10.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL range_first_invalid: DO=%h addr_err=%b required DO=00000000 addr_err=1",
                     bus10.DO, bus10.addr_err);
        end
        bus10.CS = 1'b0;
    endtask

    task automatic test_reset_ready();
        acc16(1'b1, 4'b1111, 4'd5, 32'h0);
        checks++;
        if (bus16.DO !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL rerst_pre: got %h required aaaa5555", bus16.DO);
        end
        reset_and_count16("rerst");
        read_all_zero16("rerst");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst16     = 1'b1;
        rst10     = 1'b1;
        bus16.CS  = 1'b0;
        bus16.WEB = 4'b1111;
        bus16.A   = '0;
        bus16.DI  = '0;
        bus10.CS  = 1'b0;
        bus10.WEB = 4'b1111;
        bus10.A   = '0;
        bus10.DI  = '0;
        @(posedge clk);
        #1;
        rst10 = 1'b0;

        test_reset();
        test_write_read();
        test_lanes();
        test_cs_low();
        test_back_to_back();
        test_range();
        test_reset_ready();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
